// File: rtl/cmp_bist_pkg.sv
// Shared types and sizing helpers for the comparator sweep checker.
// Sweep FSM states plus default-geometry constants; no logic lives here.
// Defaults match a 2-bit comparator with a one-cycle settle window.
package cmp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a down-counter that must hold SETTLE-1.
    function automatic int cnt_width(input int settle);
        return (settle > 2) ? $clog2(settle) : 1;
    endfunction

    localparam int DEF_WIDTH  = 2;
    localparam int DEF_SETTLE = 1;
    localparam int NUM_PAIRS  = 1 << (2 * DEF_WIDTH);
    localparam int CNT_W      = cnt_width(DEF_SETTLE);

endpackage

// File: rtl/cmp_ref_model.sv
// Golden unsigned magnitude comparison of two operands.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs continuously.
module cmp_ref_model #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             exp_gt,
    output logic             exp_eq,
    output logic             exp_lt
);

    assign exp_gt = (a > b);
    assign exp_eq = (a == b);
    assign exp_lt = (a < b);

endmodule

// File: rtl/cmp_sweep_checker.sv
// Self-test sequencer: sweeps all (A,B) pairs into a comparator and checks gt/eq/lt.
// Latency: SETTLE+1 cycles per pair; done rises (SETTLE+1)*2^(2*WIDTH) cycles after start.
// Backpressure: ena low freezes everything; start is ignored unless IDLE or DONE.
module cmp_sweep_checker
    import cmp_bist_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_gt,
    input  logic               cmp_eq,
    input  logic               cmp_lt,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int              CW       = cnt_width(SETTLE);
    localparam int              EW       = 2 * WIDTH + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            first_seen;
    logic            exp_gt;
    logic            exp_eq;
    logic            exp_lt;
    logic            mismatch;
    logic            a_max;
    logic            b_max;
    logic            last_pair;
    logic            start_ok;
    logic [EW-1:0]   err_nxt;

    cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a      (cmp_a),
        .b      (cmp_b),
        .exp_gt (exp_gt),
        .exp_eq (exp_eq),
        .exp_lt (exp_lt)
    );

    // Expected vector is always one-hot, so any non-one-hot result mismatches.
    assign mismatch  = ({cmp_gt, cmp_eq, cmp_lt} != {exp_gt, exp_eq, exp_lt});
    assign a_max     = &cmp_a;
    assign b_max     = &cmp_b;
    assign last_pair = a_max & b_max;
    assign start_ok  = start & ((state == IDLE) | (state == DONE));
    assign err_nxt   = err_count + EW'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = CHECK;
            CHECK:   state_nxt = last_pair ? DONE : WAIT;
            DONE:    if (start) state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == WAIT) | (state == CHECK);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_a      <= '0;
            cmp_b      <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            first_seen <= 1'b0;
            wait_cnt   <= '0;
            pass       <= 1'b0;
        end else if (ena) begin
            if (start_ok) begin
                cmp_a      <= '0;
                cmp_b      <= '0;
                err_count  <= '0;
                fail_a     <= '0;
                fail_b     <= '0;
                first_seen <= 1'b0;
                wait_cnt   <= CNT_LOAD;
                pass       <= 1'b0;
            end else if (state == WAIT) begin
                if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
            end else if (state == CHECK) begin
                if (mismatch) begin
                    err_count <= err_nxt;
                    if (!first_seen) begin
                        fail_a     <= cmp_a;
                        fail_b     <= cmp_b;
                        first_seen <= 1'b1;
                    end
                end
                // On the final pair the operands hold at max.
                if (!b_max) begin
                    cmp_b <= cmp_b + WIDTH'(1);
                end else if (!a_max) begin
                    cmp_b <= '0;
                    cmp_a <= cmp_a + WIDTH'(1);
                end
                wait_cnt <= CNT_LOAD;
                if (last_pair) pass <= (err_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Two checkers (SETTLE=1 and SETTLE=3) driven in lockstep against healthy and faulty comparators.
// Expected results are queued at start and checked by a monitor when done rises.
module tb_cmp_sweep_checker;

    localparam int W  = 2;
    localparam int NP = 1 << (2 * W);

    typedef struct {
        int done_cyc;
        int err;
        int fa;
        int fb;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic           start;
    logic [W-1:0]   a_s   [2];
    logic [W-1:0]   b_s   [2];
    logic           gt_s  [2];
    logic           eq_s  [2];
    logic           lt_s  [2];
    logic           busy_s[2];
    logic           done_s[2];
    logic           pass_s[2];
    logic [2*W:0]   err_s [2];
    logic [W-1:0]   fa_s  [2];
    logic [W-1:0]   fb_s  [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   cur_mode = 0;
    int   cur_fa   = 0;
    int   cur_fb   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   obs0[$];
    int   obs1[$];
    bit   done_q[2];
    int   last_err[2];

    // Comparator under test: mode 0 healthy, 1 eq stuck 0, 2 gt/lt swapped,
    // 3 all outputs high, 4 one pair (fa,fb) returns 3'b000.
    function automatic logic [2:0] resp(input int mode, input int a, input int b,
                                        input int fa, input int fb);
        logic gt, eq, lt;
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
        case (mode)
            1:       return {gt, 1'b0, lt};
            2:       return {lt, eq, gt};
            3:       return 3'b111;
            4:       return (a == fa && b == fb) ? 3'b000 : {gt, eq, lt};
            default: return {gt, eq, lt};
        endcase
    endfunction

    function automatic exp_t build(input int start_edge, input int settle, input int gap,
                                   input int mode, input int fa, input int fb);
        exp_t e;
        bit   first;
        first = 1'b1;
        e.err = 0;
        e.fa  = 0;
        e.fb  = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                if (resp(mode, a, b, fa, fb) != {a > b, a == b, a < b}) begin
                    e.err++;
                    if (first) begin
                        e.fa  = a;
                        e.fb  = b;
                        first = 1'b0;
                    end
                end
            end
        end
        e.done_cyc = start_edge + (settle + 1) * NP + gap;
        return e;
    endfunction

    function automatic int order_ok(input int o[$]);
        if (o.size() != NP) return 0;
        for (int i = 0; i < NP; i++) if (o[i] != i) return 0;
        return 1;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_zero(input int k);
        int v;
        v = int'({busy_s[k], done_s[k], pass_s[k], err_s[k], fa_s[k], fb_s[k], a_s[k], b_s[k]});
        check($sformatf("dut%0d_reset_outputs", k), v, 0);
    endtask

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(1)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .cmp_a     (a_s[0]),
        .cmp_b     (b_s[0]),
        .cmp_gt    (gt_s[0]),
        .cmp_eq    (eq_s[0]),
        .cmp_lt    (lt_s[0]),
        .busy      (busy_s[0]),
        .done      (done_s[0]),
        .pass      (pass_s[0]),
        .err_count (err_s[0]),
        .fail_a    (fa_s[0]),
        .fail_b    (fb_s[0])
    );

    cmp_sweep_checker #(.WIDTH(W), .SETTLE(3)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .cmp_a     (a_s[1]),
        .cmp_b     (b_s[1]),
        .cmp_gt    (gt_s[1]),
        .cmp_eq    (eq_s[1]),
        .cmp_lt    (lt_s[1]),
        .busy      (busy_s[1]),
        .done      (done_s[1]),
        .pass      (pass_s[1]),
        .err_count (err_s[1]),
        .fail_a    (fa_s[1]),
        .fail_b    (fb_s[1])
    );

    assign {gt_s[0], eq_s[0], lt_s[0]} = resp(cur_mode, int'(a_s[0]), int'(b_s[0]), cur_fa, cur_fb);
    assign {gt_s[1], eq_s[1], lt_s[1]} = resp(cur_mode, int'(a_s[1]), int'(b_s[1]), cur_fa, cur_fb);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: records the operand sequence and scores each rising done.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                if (k == 0) obs0.delete(); else obs1.delete();
            end else begin
                int   pr;
                int   n;
                exp_t e;
                pr = int'({a_s[k], b_s[k]});
                if (busy_s[k]) begin
                    if (k == 0) begin
                        if (obs0.size() == 0 || obs0[$] != pr) obs0.push_back(pr);
                    end else begin
                        if (obs1.size() == 0 || obs1[$] != pr) obs1.push_back(pr);
                    end
                end
                if (done_s[k] && !done_q[k]) begin
                    n = (k == 0) ? q0.size() : q1.size();
                    if (n == 0) begin
                        check($sformatf("dut%0d_unexpected_done", k), 1, 0);
                    end else begin
                        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                        check($sformatf("dut%0d_done_cycle", k), cyc, e.done_cyc);
                        check($sformatf("dut%0d_err_count", k), int'(err_s[k]), e.err);
                        check($sformatf("dut%0d_pass", k), int'(pass_s[k]), (e.err == 0) ? 1 : 0);
                        check($sformatf("dut%0d_fail_a", k), int'(fa_s[k]), e.fa);
                        check($sformatf("dut%0d_fail_b", k), int'(fb_s[k]), e.fb);
                        check($sformatf("dut%0d_sweep_order", k),
                              (k == 0) ? order_ok(obs0) : order_ok(obs1), 1);
                        last_err[k] = e.err;
                    end
                    if (k == 0) obs0.delete(); else obs1.delete();
                end
            end
            done_q[k] = done_s[k];
        end
    end

    task automatic run(input int mode, input int gap, input int gap_at,
                       input bit busy_start, input int fa, input int fb);
        cur_mode = mode;
        cur_fa   = fa;
        cur_fb   = fb;
        @(negedge clk);
        q0.push_back(build(cyc + 1, 1, gap, mode, fa, fb));
        q1.push_back(build(cyc + 1, 3, gap, mode, fa, fb));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t < 400 && (q0.size() != 0 || q1.size() != 0); t++) begin
            start = busy_start && (t == 3 || t == 20);
            ena   = !(gap > 0 && t >= gap_at && t < gap_at + gap);
            @(negedge clk);
        end
        start = 1'b0;
        ena   = 1'b1;
        if (q0.size() != 0 || q1.size() != 0) begin
            check("done_timeout", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_done_hold", k), int'(done_s[k]), 1);
            check($sformatf("dut%0d_pass_hold", k), int'(pass_s[k]), (last_err[k] == 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 0, 1'b0, 0, 0);
        run(1, 0, 0, 1'b0, 0, 0);
        run(2, 0, 0, 1'b0, 0, 0);
        run(3, 0, 0, 1'b0, 0, 0);
        run(0, 5, 6, 1'b1, 0, 0);

        // Reset in the middle of a sweep, then a fresh sweep.
        cur_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        repeat (2) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            run($urandom_range(0, 4), $urandom_range(0, 8), $urandom_range(2, 20),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
